captura_clave: RTL and testbench

Keypad PIN-entry stage that sits directly upstream of the gate access controller. It collects BCD digits from the keypad scanner while a vehicle is present and edits them with backspace and cancel keys. On the enter key it publishes a complete 4-digit PIN as `clave_ingresada` together with a one-cycle strobe. The access controller compares that value against the stored PIN; this block performs no comparison.

---
 rtl/acceso_pkg.sv | 33 +++
 rtl/detector_flanco.sv | 21 ++
 rtl/captura_clave.sv | 162 ++++++++++++++++
 tb/tb_captura_clave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acceso_pkg.sv
// Shared definitions for the gate access path: key codes, entry states and
// the factory PIN the access controller falls back to.
package acceso_pkg;

  localparam logic [3:0]  TECLA_DIGITO_MAX  = 4'h9;
  localparam logic [3:0]  TECLA_BORRAR      = 4'hA;
  localparam logic [3:0]  TECLA_ENTER       = 4'hB;
  localparam logic [3:0]  TECLA_CANCELAR    = 4'hC;
  localparam logic [15:0] CLAVE_POR_DEFECTO = 16'h2468;

  typedef enum logic [1:0] {
    INACTIVO,
    ESPERA,
    COMPLETA
  } estado_t;

  typedef enum logic [2:0] {
    K_DIGITO,
    K_BORRAR,
    K_ENTER,
    K_CANCELAR,
    K_INVALIDA
  } clase_tecla_t;

  function automatic clase_tecla_t clasificar(input logic [3:0] codigo);
    if (codigo <= TECLA_DIGITO_MAX)     return K_DIGITO;
    else if (codigo == TECLA_BORRAR)    return K_BORRAR;
    else if (codigo == TECLA_ENTER)     return K_ENTER;
    else if (codigo == TECLA_CANCELAR)  return K_CANCELAR;
    else                                return K_INVALIDA;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Single-bit rising-edge detector: the output is high in the cycle the input
// rises, combinationally, against the registered previous value.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic senal,
  output logic flanco
);

  logic senal_prev;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) senal_prev <= 1'b0;
    else        senal_prev <= senal;
  end

  assign flanco = senal & ~senal_prev;

endmodule

// File: rtl/captura_clave.sv
// Keypad PIN entry: collects BCD digits while a vehicle is present, supports
// backspace/cancel, and publishes the complete PIN on enter with a strobe.
module captura_clave
  import acceso_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int NUM_DIGITOS    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               llegado_vehiculo,
  input  logic                               tecla_valida,
  input  logic [3:0]                         codigo_tecla,
  output logic [4*NUM_DIGITOS-1:0]           clave_ingresada,
  output logic                               clave_lista,
  output logic [$clog2(NUM_DIGITOS+1)-1:0]   digitos_ingresados,
  output logic                               error_tecla
);

  localparam int ANCHO_CLAVE  = 4 * NUM_DIGITOS;
  localparam int ANCHO_CUENTA = $clog2(NUM_DIGITOS + 1);
  localparam int ANCHO_OCIO   = $clog2(TIMEOUT_CICLOS + 1);

  localparam logic [ANCHO_CUENTA-1:0] CUENTA_LLENA = ANCHO_CUENTA'(NUM_DIGITOS);
  localparam logic [ANCHO_CUENTA-1:0] CUENTA_UNO   = ANCHO_CUENTA'(1);
  localparam logic [ANCHO_OCIO-1:0]   OCIO_MAX     = ANCHO_OCIO'(TIMEOUT_CICLOS);
  localparam logic [ANCHO_OCIO-1:0]   OCIO_UNO     = ANCHO_OCIO'(1);

  estado_t                  estado, estado_next;
  logic [ANCHO_CLAVE-1:0]   buffer, buffer_next;
  logic [ANCHO_CUENTA-1:0]  cuenta, cuenta_next;
  logic [ANCHO_OCIO-1:0]    ocio, ocio_next;
  logic [ANCHO_CLAVE-1:0]   clave_next;
  logic                     lista_next, error_next;

  logic         flanco;
  logic         en_edicion, tecla_aceptada, vencido;
  clase_tecla_t clase;

  detector_flanco u_flanco (
    .clk    (clk),
    .reset  (reset),
    .senal  (tecla_valida),
    .flanco (flanco)
  );

  // Departure outranks everything, then the idle timeout, then the key.
  assign clase          = clasificar(codigo_tecla);
  assign en_edicion     = llegado_vehiculo && (estado != INACTIVO);
  assign tecla_aceptada = en_edicion && flanco;
  assign vencido        = en_edicion && (cuenta != '0) && (ocio == OCIO_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= INACTIVO;
    else        estado <= estado_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_next = estado;
    if (!llegado_vehiculo) begin
      estado_next = INACTIVO;
    end else begin
      unique case (estado)
        INACTIVO: estado_next = ESPERA;
        ESPERA: begin
          if (!vencido && tecla_aceptada && clase == K_DIGITO &&
              cuenta == CUENTA_LLENA - CUENTA_UNO)
            estado_next = COMPLETA;
        end
        COMPLETA: begin
          if (vencido)
            estado_next = ESPERA;
          else if (tecla_aceptada &&
                   (clase == K_BORRAR || clase == K_ENTER || clase == K_CANCELAR))
            estado_next = ESPERA;
        end
        default: estado_next = INACTIVO;
      endcase
    end
  end

  always_comb begin
    buffer_next = buffer;
    cuenta_next = cuenta;
    clave_next  = clave_ingresada;
    lista_next  = 1'b0;
    error_next  = 1'b0;

    if (!en_edicion) begin
      buffer_next = '0;
      cuenta_next = '0;
    end else if (vencido) begin
      buffer_next = '0;
      cuenta_next = '0;
      error_next  = 1'b1;
    end else if (tecla_aceptada) begin
      unique case (clase)
        K_DIGITO: begin
          if (estado == COMPLETA) begin
            error_next = 1'b1;
          end else begin
            buffer_next = {buffer[ANCHO_CLAVE-5:0], codigo_tecla};
            cuenta_next = cuenta + CUENTA_UNO;
          end
        end
        K_BORRAR: begin
          if (cuenta != '0) begin
            buffer_next = {4'h0, buffer[ANCHO_CLAVE-1:4]};
            cuenta_next = cuenta - CUENTA_UNO;
          end
        end
        K_ENTER: begin
          if (estado == COMPLETA) begin
            clave_next = buffer;
            lista_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
          buffer_next = '0;
          cuenta_next = '0;
        end
        K_CANCELAR: begin
          buffer_next = '0;
          cuenta_next = '0;
        end
        default: error_next = 1'b1;
      endcase
    end
  end

  // Idle counter only runs while a partial entry exists, and saturates.
  always_comb begin
    ocio_next = ocio;
    if (!en_edicion || tecla_aceptada || vencido || cuenta == '0)
      ocio_next = '0;
    else if (ocio != OCIO_MAX)
      ocio_next = ocio + OCIO_UNO;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer          <= '0;
      cuenta          <= '0;
      ocio            <= '0;
      clave_ingresada <= '0;
      clave_lista     <= 1'b0;
      error_tecla     <= 1'b0;
    end else begin
      buffer          <= buffer_next;
      cuenta          <= cuenta_next;
      ocio            <= ocio_next;
      clave_ingresada <= clave_next;
      clave_lista     <= lista_next;
      error_tecla     <= error_next;
    end
  end

  assign digitos_ingresados = cuenta;

endmodule

// File: tb/tb_captura_clave.sv
// Self-checking bench for captura_clave: table of key presses plus hand-written
// sequences for held strobe, timeout, vehicle departure and mid-entry reset.
module tb_captura_clave;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        lv;
  logic        valida;
  logic [3:0]  codigo;
  logic [15:0] clave;
  logic        lista;
  logic [2:0]  digitos;
  logic        err;

  always #5 clk = ~clk;

  captura_clave #(
    .TIMEOUT_CICLOS (T),
    .NUM_DIGITOS    (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .llegado_vehiculo   (lv),
    .tecla_valida       (valida),
    .codigo_tecla       (codigo),
    .clave_ingresada    (clave),
    .clave_lista        (lista),
    .digitos_ingresados (digitos),
    .error_tecla        (err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cola[$];
  logic [15:0] clave_modelo;

  typedef struct {
    logic [3:0]  c;
    logic [2:0]  cnt;
    logic        e;
    logic        l;
    logic [15:0] k;
  } paso_t;

  paso_t tabla[35];

  task automatic check(input string nombre, input logic [31:0] actual,
                       input logic [31:0] esperado);
    n_cmp++;
    if (actual !== esperado) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nombre, actual, esperado);
    end
  endtask

  // Scoreboard: every published PIN must match the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && (lista || err))
      check("pulsos_exclusivos", 32'(lista & err), 32'd0);
    if (reset === 1'b1 && lista) begin
      check("lista_esperada", 32'(cola.size() != 0), 32'd1);
      if (cola.size() != 0) check("clave_publicada", clave, cola.pop_front());
    end
  end

  // Called at a falling edge; the key edge lands on the next rising edge.
  task automatic pulsa(input logic [3:0] c, input logic [2:0] e_cnt,
                       input logic e_err, input logic e_lista,
                       input logic [15:0] e_clave, input string tag);
    if (e_lista) begin
      cola.push_back(e_clave);
      clave_modelo = e_clave;
    end
    codigo = c;
    valida = 1'b1;
    @(negedge clk);
    check({tag, " cuenta"}, digitos, e_cnt);
    check({tag, " error"}, err, e_err);
    check({tag, " lista"}, lista, e_lista);
    check({tag, " clave"}, clave, clave_modelo);
    valida = 1'b0;
    @(negedge clk);
    check({tag, " ancho_pulso"}, {lista, err}, 2'b00);
  endtask

  task automatic run_tabla(input int a, input int b);
    for (int i = a; i <= b; i++)
      pulsa(tabla[i].c, tabla[i].cnt, tabla[i].e, tabla[i].l, tabla[i].k,
            $sformatf("paso%0d", i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int espera;
    logic disparo;

    reset = 1'b0; lv = 1'b0; valida = 1'b0; codigo = 4'h0;
    clave_modelo = 16'h0000;

    // Normal entry
    tabla[0]  = '{4'h1, 3'd1, 1'b0, 1'b0, 16'h0};
    tabla[1]  = '{4'h1, 3'd2, 1'b0, 1'b0, 16'h0};
    tabla[2]  = '{4'h9, 3'd3, 1'b0, 1'b0, 16'h0};
    tabla[3]  = '{4'h4, 3'd4, 1'b0, 1'b0, 16'h0};
    tabla[4]  = '{4'hB, 3'd0, 1'b0, 1'b1, 16'h1194};
    // Editing with backspace
    tabla[5]  = '{4'h1, 3'd1, 1'b0, 1'b0, 16'h0};
    tabla[6]  = '{4'h2, 3'd2, 1'b0, 1'b0, 16'h0};
    tabla[7]  = '{4'hA, 3'd1, 1'b0, 1'b0, 16'h0};
    tabla[8]  = '{4'h3, 3'd2, 1'b0, 1'b0, 16'h0};
    tabla[9]  = '{4'h4, 3'd3, 1'b0, 1'b0, 16'h0};
    tabla[10] = '{4'h5, 3'd4, 1'b0, 1'b0, 16'h0};
    tabla[11] = '{4'hB, 3'd0, 1'b0, 1'b1, 16'h1345};
    // Enter on a short entry
    tabla[12] = '{4'h1, 3'd1, 1'b0, 1'b0, 16'h0};
    tabla[13] = '{4'h2, 3'd2, 1'b0, 1'b0, 16'h0};
    tabla[14] = '{4'hB, 3'd0, 1'b1, 1'b0, 16'h0};
    // Overflow
    tabla[15] = '{4'h2, 3'd1, 1'b0, 1'b0, 16'h0};
    tabla[16] = '{4'h4, 3'd2, 1'b0, 1'b0, 16'h0};
    tabla[17] = '{4'h6, 3'd3, 1'b0, 1'b0, 16'h0};
    tabla[18] = '{4'h8, 3'd4, 1'b0, 1'b0, 16'h0};
    tabla[19] = '{4'h9, 3'd4, 1'b1, 1'b0, 16'h0};
    tabla[20] = '{4'hB, 3'd0, 1'b0, 1'b1, 16'h2468};
    // Invalid code, cancel, backspace on empty
    tabla[21] = '{4'h1, 3'd1, 1'b0, 1'b0, 16'h0};
    tabla[22] = '{4'h2, 3'd2, 1'b0, 1'b0, 16'h0};
    tabla[23] = '{4'hE, 3'd2, 1'b1, 1'b0, 16'h0};
    tabla[24] = '{4'hC, 3'd0, 1'b0, 1'b0, 16'h0};
    tabla[25] = '{4'hA, 3'd0, 1'b0, 1'b0, 16'h0};
    // Backspace from a full entry
    tabla[26] = '{4'h5, 3'd1, 1'b0, 1'b0, 16'h0};
    tabla[27] = '{4'h6, 3'd2, 1'b0, 1'b0, 16'h0};
    tabla[28] = '{4'h7, 3'd3, 1'b0, 1'b0, 16'h0};
    tabla[29] = '{4'h8, 3'd4, 1'b0, 1'b0, 16'h0};
    tabla[30] = '{4'hA, 3'd3, 1'b0, 1'b0, 16'h0};
    tabla[31] = '{4'h9, 3'd4, 1'b0, 1'b0, 16'h0};
    tabla[32] = '{4'hB, 3'd0, 1'b0, 1'b1, 16'h5679};
    // Invalid code and enter on an empty entry
    tabla[33] = '{4'hF, 3'd0, 1'b1, 1'b0, 16'h0};
    tabla[34] = '{4'hB, 3'd0, 1'b1, 1'b0, 16'h0};

    #12;
    check("reset clave", clave, 16'h0000);
    check("reset lista", lista, 1'b0);
    check("reset cuenta", digitos, 3'd0);
    check("reset error", err, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    pulsa(4'h5, 3'd0, 1'b0, 1'b0, 16'h0, "inactivo");

    lv = 1'b1;
    @(negedge clk);
    check("espera cuenta", digitos, 3'd0);
    run_tabla(0, 34);
    check("cola_vacia tabla", cola.size(), 0);

    // Held strobe counts once
    codigo = 4'h7;
    valida = 1'b1;
    repeat (5) @(negedge clk);
    check("sostenida cuenta", digitos, 3'd1);
    valida = 1'b0;
    @(negedge clk);
    pulsa(4'h1, 3'd2, 1'b0, 1'b0, 16'h0, "sost1");
    pulsa(4'h2, 3'd3, 1'b0, 1'b0, 16'h0, "sost2");
    pulsa(4'h3, 3'd4, 1'b0, 1'b0, 16'h0, "sost3");
    pulsa(4'hB, 3'd0, 1'b0, 1'b1, 16'h7123, "sost_enter");

    // Timeout on a partial entry
    pulsa(4'h5, 3'd1, 1'b0, 1'b0, 16'h0, "tmo1");
    pulsa(4'h6, 3'd2, 1'b0, 1'b0, 16'h0, "tmo2");
    espera = 0;
    for (int i = 1; i <= T + 4; i++) begin
      @(negedge clk);
      if (err) begin
        espera = i;
        break;
      end
    end
    check("timeout detectado", 32'(espera != 0), 32'd1);
    check("timeout ventana", 32'(espera >= T - 1 && espera <= T + 1), 32'd1);
    check("timeout cuenta", digitos, 3'd0);
    @(negedge clk);
    check("timeout ancho", err, 1'b0);

    disparo = 1'b0;
    repeat (T + 3) begin
      @(negedge clk);
      if (err) disparo = 1'b1;
    end
    check("sin timeout vacio", disparo, 1'b0);

    // Departure in the same cycle as a digit edge
    pulsa(4'h1, 3'd1, 1'b0, 1'b0, 16'h0, "sal1");
    pulsa(4'h2, 3'd2, 1'b0, 1'b0, 16'h0, "sal2");
    pulsa(4'h3, 3'd3, 1'b0, 1'b0, 16'h0, "sal3");
    codigo = 4'h4;
    valida = 1'b1;
    lv = 1'b0;
    @(negedge clk);
    check("salida cuenta", digitos, 3'd0);
    check("salida error", err, 1'b0);
    check("salida clave", clave, clave_modelo);
    valida = 1'b0;
    lv = 1'b1;
    @(negedge clk);
    pulsa(4'h5, 3'd1, 1'b0, 1'b0, 16'h0, "vuelta1");
    pulsa(4'h6, 3'd2, 1'b0, 1'b0, 16'h0, "vuelta2");
    pulsa(4'h7, 3'd3, 1'b0, 1'b0, 16'h0, "vuelta3");
    pulsa(4'h8, 3'd4, 1'b0, 1'b0, 16'h0, "vuelta4");
    pulsa(4'hB, 3'd0, 1'b0, 1'b1, 16'h5678, "vuelta_enter");
    check("cola_vacia vuelta", cola.size(), 0);

    // Asynchronous reset mid-entry
    pulsa(4'h9, 3'd1, 1'b0, 1'b0, 16'h0, "rst1");
    pulsa(4'h8, 3'd2, 1'b0, 1'b0, 16'h0, "rst2");
    pulsa(4'h7, 3'd3, 1'b0, 1'b0, 16'h0, "rst3");
    #2 reset = 1'b0;
    #1;
    check("rst_async clave", clave, 16'h0000);
    check("rst_async cuenta", digitos, 3'd0);
    check("rst_async lista", lista, 1'b0);
    check("rst_async error", err, 1'b0);
    clave_modelo = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_tabla(0, 4);
    check("cola_vacia final", cola.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
